top_pixel_hierarchy: RTL and testbench

Two-level event arbiter for a ROWS x COLS event-camera pixel array.
- The array is tiled into groups of GRP_ROWS x GRP_COLS pixels.
- A level-2 round-robin arbiter selects one active group. A level-1 round-robin arbiter inside that group grants one pixel per cycle until the group is drained.
- Each grant emits an address/polarity event word.
- The block sits between the pixel array and the event readout/serialiser.

---
 rtl/lib_arbiter_pkg.sv | 50 +++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/top_pixel_hierarchy.sv | 180 ++++++++++++++++++
 tb/tb_top_pixel_hierarchy.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared geometry and widths for the two-level pixel event arbiter.
//   ROWS x COLS pixel array, tiled into GRP_ROWS x GRP_COLS groups.
//   NUM_GRP  : number of groups (row-major group index)
//   GRP_SIZE : pixels per group (row-major pixel index inside a group)
//   WIDTH    : event word width; grows by TS_WIDTH when the build defines
//              PIXEL_TIMESTAMP_EN.
// Helper functions map (group, pixel-in-group) to array row/column.
// -----------------------------------------------------------------------------
package lib_arbiter_pkg;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int POLARITY = 2;   // bit0 = ON, bit1 = OFF
  localparam int GRP_ROWS = 2;
  localparam int GRP_COLS = 2;

  localparam int GRP_PER_ROW = COLS / GRP_COLS;
  localparam int NUM_GRP     = (ROWS / GRP_ROWS) * GRP_PER_ROW;
  localparam int GRP_SIZE    = GRP_ROWS * GRP_COLS;

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int PIX_W = (GRP_SIZE > 1) ? $clog2(GRP_SIZE) : 1;

  localparam int TS_WIDTH  = 16;
  localparam int EVT_WIDTH = ROW_W + COL_W + POLARITY;

`ifdef PIXEL_TIMESTAMP_EN
  localparam int WIDTH = TS_WIDTH + EVT_WIDTH;
`else
  localparam int WIDTH = EVT_WIDTH;
`endif

  typedef logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] pix_req_t;
  typedef logic [ROWS-1:0][COLS-1:0]               pix_map_t;

  // Array row of pixel p inside group g.
  function automatic int pix_row(input int g, input int p);
    return (g / GRP_PER_ROW) * GRP_ROWS + (p / GRP_COLS);
  endfunction

  // Array column of pixel p inside group g.
  function automatic int pix_col(input int g, input int p);
    return (g % GRP_PER_ROW) * GRP_COLS + (p % GRP_COLS);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping round.
//   req : N request lines
//   ptr : starting index (must be < N)
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted line (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   cand;   // one extra bit so ptr + k cannot overflow

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/top_pixel_hierarchy.sv
// -----------------------------------------------------------------------------
// top_pixel_hierarchy
// Two-level event arbiter between an event-camera pixel array and the readout.
// Level 2 round-robins over pixel groups and locks one; level 1 round-robins
// over the pixels of the locked group, one grant per cycle, until drained.
//
// Ports
//   clk_i             : clock, rising edge
//   reset_i           : synchronous active-high reset
//   req_i             : per-pixel request, [row][col][polarity]
//   gnt_out_o         : one-hot grant pulse, [row][col]
//   grp_release_out_o : pulses with the grant that empties the locked group
//   data_out_o        : event word {row, col, polarity}, row in MSBs
//
// Build option: PIXEL_TIMESTAMP_EN prepends a free-running TS_WIDTH-bit
// cycle counter to data_out_o, captured on the grant edge.
// -----------------------------------------------------------------------------
module top_pixel_hierarchy
  import lib_arbiter_pkg::*;
(
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0]  req_i,
  output logic [ROWS-1:0][COLS-1:0]                gnt_out_o,
  output logic                                     grp_release_out_o,
  output logic [WIDTH-1:0]                         data_out_o
);

  // Registered state
  pix_map_t            gnt_reg, gnt_next;
  logic                rel_reg, rel_next;
  logic [WIDTH-1:0]    data_reg, data_next;
  logic                locked_reg, locked_next;
  logic [GRP_W-1:0]    lock_grp_reg, lock_grp_next;
  logic [GRP_W-1:0]    l2_ptr_reg, l2_ptr_next;
  logic [PIX_W-1:0]    l1_ptr_reg, l1_ptr_next;

  // Request fabric
  pix_map_t                          act_pix;
  logic [NUM_GRP-1:0][GRP_SIZE-1:0]  grp_req;
  logic [NUM_GRP-1:0]                grp_any;

  // Arbiter interconnect
  logic [NUM_GRP-1:0]   l2_gnt;
  logic [GRP_W-1:0]     l2_idx;
  logic [GRP_SIZE-1:0]  l1_req;
  logic [GRP_SIZE-1:0]  l1_gnt;
  logic [PIX_W-1:0]     l1_idx;
  logic                 use_lock;
  logic                 any_req;
  logic                 grp_drained;
  logic [GRP_W-1:0]     sel_grp;
  logic [ROW_W-1:0]     grant_row;
  logic [COL_W-1:0]     grant_col;
  logic [EVT_WIDTH-1:0] evt_word;

`ifdef PIXEL_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]  ts_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + TS_WIDTH'(1);
    end
  end
`endif

  // A pixel granted last cycle is masked so its one-cycle drop latency
  // cannot produce a duplicate grant.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign act_pix[gi][gj] = (|req_i[gi][gj]) & ~gnt_reg[gi][gj];
    end
  end

  // Regroup the masked requests as [group][pixel-in-group], both row-major.
  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    for (genvar gp = 0; gp < GRP_SIZE; gp++) begin : g_pix
      localparam int PR = pix_row(gi, gp);
      localparam int PC = pix_col(gi, gp);
      assign grp_req[gi][gp] = act_pix[PR][PC];
    end
    assign grp_any[gi] = |grp_req[gi];
  end

  // Level 2: next group after the last one served.
  rr_arbiter #(
    .N     (NUM_GRP),
    .IDX_W (GRP_W)
  ) u_l2_arb (
    .req (grp_any),
    .ptr (l2_ptr_reg),
    .gnt (l2_gnt),
    .idx (l2_idx)
  );

  // Stay on the locked group while it still has work; otherwise take the
  // level-2 pick in the same cycle so there is no bubble between groups.
  assign use_lock = locked_reg & grp_any[lock_grp_reg];
  assign any_req  = |l2_gnt;
  assign sel_grp  = use_lock ? lock_grp_reg : l2_idx;
  assign l1_req   = grp_req[sel_grp];

  // Level 1: pixel inside the selected group.
  rr_arbiter #(
    .N     (GRP_SIZE),
    .IDX_W (PIX_W)
  ) u_l1_arb (
    .req (l1_req),
    .ptr (l1_ptr_reg),
    .gnt (l1_gnt),
    .idx (l1_idx)
  );

  // Group is drained when the pixel being granted is its last masked request.
  assign grp_drained = ~|(l1_req & ~l1_gnt);

  always_comb begin
    grant_row = ROW_W'(pix_row(int'(sel_grp), int'(l1_idx)));
    grant_col = COL_W'(pix_col(int'(sel_grp), int'(l1_idx)));
    evt_word  = {grant_row, grant_col, req_i[grant_row][grant_col]};
  end

  // Next-state logic
  always_comb begin
    gnt_next      = '0;
    rel_next      = 1'b0;
    data_next     = data_reg;
    locked_next   = locked_reg;
    lock_grp_next = lock_grp_reg;
    l2_ptr_next   = l2_ptr_reg;
    l1_ptr_next   = l1_ptr_reg;

    if (any_req) begin
      gnt_next[grant_row][grant_col] = 1'b1;
`ifdef PIXEL_TIMESTAMP_EN
      data_next = {ts_reg, evt_word};
`else
      data_next = evt_word;
`endif
      l1_ptr_next = (l1_idx == PIX_W'(GRP_SIZE - 1)) ? '0 : l1_idx + PIX_W'(1);

      if (grp_drained) begin
        rel_next    = 1'b1;
        locked_next = 1'b0;
        l2_ptr_next = (sel_grp == GRP_W'(NUM_GRP - 1)) ? '0 : sel_grp + GRP_W'(1);
      end else begin
        locked_next   = 1'b1;
        lock_grp_next = sel_grp;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gnt_reg      <= '0;
      rel_reg      <= 1'b0;
      data_reg     <= '0;
      locked_reg   <= 1'b0;
      lock_grp_reg <= '0;
      l2_ptr_reg   <= '0;
      l1_ptr_reg   <= '0;
    end else begin
      gnt_reg      <= gnt_next;
      rel_reg      <= rel_next;
      data_reg     <= data_next;
      locked_reg   <= locked_next;
      lock_grp_reg <= lock_grp_next;
      l2_ptr_reg   <= l2_ptr_next;
      l1_ptr_reg   <= l1_ptr_next;
    end
  end

  assign gnt_out_o         = gnt_reg;
  assign grp_release_out_o = rel_reg;
  assign data_out_o        = data_reg;

endmodule

// File: tb/tb_top_pixel_hierarchy.sv
// -----------------------------------------------------------------------------
// tb_top_pixel_hierarchy
// Scenario tasks drive per-cycle steps, push the expected outputs to a
// scoreboard queue, and pop/compare after the following rising edge.
// -----------------------------------------------------------------------------
module tb_top_pixel_hierarchy;
  import lib_arbiter_pkg::*;

  localparam int BASE_W = ROW_W + COL_W + POLARITY;

  logic             clk_i = 1'b0;
  logic             reset_i;
  pix_req_t         req_i;
  pix_map_t         gnt_out_o;
  logic             grp_release_out_o;
  logic [WIDTH-1:0] data_out_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              rst;
    pix_req_t          req;
    logic              gv;
    int                gr;
    int                gc;
    logic              rel;
    logic [BASE_W-1:0] dat;
  } step_t;

  typedef struct {
    pix_map_t          gnt;
    logic              rel;
    logic [BASE_W-1:0] dat;
  } exp_t;

  exp_t              exp_q[$];
  logic [BASE_W-1:0] last_dat;

  always #5 clk_i = ~clk_i;

  top_pixel_hierarchy dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .req_i             (req_i),
    .gnt_out_o         (gnt_out_o),
    .grp_release_out_o (grp_release_out_o),
    .data_out_o        (data_out_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic pix_req_t px(input int r, input int c, input logic [POLARITY-1:0] p);
    pix_req_t v = '0;
    v[r][c] = p;
    return v;
  endfunction

  function automatic step_t st(input logic rst, input pix_req_t req, input logic gv,
                               input int gr, input int gc, input logic rel,
                               input logic [BASE_W-1:0] dat);
    step_t s;
    s.rst = rst; s.req = req; s.gv = gv; s.gr = gr; s.gc = gc; s.rel = rel; s.dat = dat;
    return s;
  endfunction

  // Drive one cycle of stimulus and push what the outputs must be after the edge.
  task automatic drive_step(input step_t s);
    exp_t e;
    reset_i = s.rst;
    req_i   = s.req;
    e.gnt   = '0;
    e.rel   = 1'b0;
    if (s.rst) begin
      last_dat = '0;
    end else if (s.gv) begin
      e.gnt[s.gr][s.gc] = 1'b1;
      e.rel             = s.rel;
      last_dat          = s.dat;
    end
    e.dat = last_dat;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = '0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i  = 1'b0;
    last_dat = '0;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    do_reset();
    for (int k = 0; k < 2; k++)
      s.push_back(st(1'b1, pix_req_t'({$urandom, $urandom, $urandom, $urandom}), 1'b0, 0, 0, 1'b0, '0));
    for (int k = 0; k < 10; k++)
      s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL reset[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL reset[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL reset[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("reset[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  task automatic test_single();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(st(1'b0, px(1, 2, 2'b01), 1'b1, 1, 2, 1'b1, 8'h29));
    s.push_back(st(1'b0, px(1, 2, 2'b01), 1'b0, 0, 0, 1'b0, '0));   // masked: no regrant
    s.push_back(st(1'b0, '0,              1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL single[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL single[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL single[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("single[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  task automatic test_pair();
    step_t    s[$];
    exp_t     e;
    pix_req_t r;
    do_reset();
    r = px(0, 0, 2'b01) | px(0, 1, 2'b10);
    s.push_back(st(1'b0, r,  1'b1, 0, 0, 1'b0, 8'h01));
    s.push_back(st(1'b0, r,  1'b1, 0, 1, 1'b1, 8'h06));
    s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL pair[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL pair[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL pair[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("pair[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  task automatic test_two_groups();
    step_t    s[$];
    exp_t     e;
    pix_req_t r;
    do_reset();
    r = px(0, 0, 2'b01) | px(2, 2, 2'b10);
    s.push_back(st(1'b0, r,  1'b1, 0, 0, 1'b1, 8'h01));
    s.push_back(st(1'b0, r,  1'b1, 2, 2, 1'b1, 8'h4A));
    s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL groups[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL groups[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL groups[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("groups[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  // Held single request, polarity 11: grants only on alternate edges.
  task automatic test_alternate();
    step_t    s[$];
    exp_t     e;
    pix_req_t r;
    do_reset();
    r = px(3, 5, 2'b11);
    for (int k = 0; k < 6; k++)
      s.push_back(st(1'b0, r, (k % 2 == 0), 3, 5, 1'b1, 8'h77));
    s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL alternate[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL alternate[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL alternate[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("alternate[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  // Late request in the locked group joins the burst; next group follows.
  task automatic test_join();
    step_t    s[$];
    exp_t     e;
    pix_req_t r1, r2, r3;
    do_reset();
    r1 = px(0, 0, 2'b01) | px(0, 1, 2'b01);
    r2 = r1 | px(1, 1, 2'b10) | px(0, 2, 2'b01);
    r3 = px(1, 1, 2'b10) | px(0, 2, 2'b01);
    s.push_back(st(1'b0, r1, 1'b1, 0, 0, 1'b0, 8'h01));
    s.push_back(st(1'b0, r2, 1'b1, 0, 1, 1'b0, 8'h05));
    s.push_back(st(1'b0, r3, 1'b1, 1, 1, 1'b1, 8'h26));
    s.push_back(st(1'b0, r3, 1'b1, 0, 2, 1'b1, 8'h09));
    s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL join[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL join[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL join[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("join[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    step_t    s[$];
    exp_t     e;
    pix_req_t r;
    do_reset();
    r = px(0, 0, 2'b01) | px(0, 1, 2'b10) | px(1, 0, 2'b11) | px(1, 1, 2'b01);
    s.push_back(st(1'b0, r,  1'b1, 0, 0, 1'b0, 8'h01));
    s.push_back(st(1'b1, r,  1'b0, 0, 0, 1'b0, '0));
    s.push_back(st(1'b0, r,  1'b1, 0, 0, 1'b0, 8'h01));
    s.push_back(st(1'b0, r,  1'b1, 0, 1, 1'b0, 8'h06));
    s.push_back(st(1'b0, r,  1'b1, 1, 0, 1'b0, 8'h23));
    s.push_back(st(1'b0, '0, 1'b0, 0, 0, 1'b0, '0));
    foreach (s[k]) begin
      drive_step(s[k]);
      @(posedge clk_i); #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt_out_o !== e.gnt) begin errors++; $display("FAIL midreset[%0d] gnt got %h want %h", k, gnt_out_o, e.gnt); end
      checks++;
      if (grp_release_out_o !== e.rel) begin errors++; $display("FAIL midreset[%0d] release got %b want %b", k, grp_release_out_o, e.rel); end
      checks++;
      if (data_out_o[BASE_W-1:0] !== e.dat) begin errors++; $display("FAIL midreset[%0d] data got %h want %h", k, data_out_o[BASE_W-1:0], e.dat); end
      $display("midreset[%0d] gnt=%h rel=%b data=%h", k, gnt_out_o, grp_release_out_o, data_out_o);
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    req_i    = '0;
    last_dat = '0;
    test_reset();
    test_single();
    test_pair();
    test_two_groups();
    test_alternate();
    test_join();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
